// File: rtl/mem_arb_pkg.sv
// Shared types and port identifiers for the main-memory arbiter.
// Port ids double as bit positions in the one-hot grant vector {if, dt, ld}.
package mem_arb_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  localparam logic [1:0] PORT_LD   = 2'd0;
  localparam logic [1:0] PORT_DT   = 2'd1;
  localparam logic [1:0] PORT_IF   = 2'd2;
  localparam logic [1:0] PORT_NONE = 2'd3;

  // Collapse a one-hot (or empty) grant vector into its port id.
  function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
    logic [1:0] id;
    id = PORT_NONE;
    if (oh[PORT_LD])      id = PORT_LD;
    else if (oh[PORT_DT]) id = PORT_DT;
    else if (oh[PORT_IF]) id = PORT_IF;
    return id;
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational priority selector: ld > dt > if, with a starved fetch
// promoted above dt. During boot only the loader is eligible.
module arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic       ld_req,
  input  logic       dt_req,
  input  logic       if_req,
  input  logic       boot,
  input  logic       starved,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    gnt = '0;
    if (ld_req) begin
      gnt[PORT_LD] = 1'b1;
    end else if (!boot) begin
      if (if_req && starved)  gnt[PORT_IF] = 1'b1;
      else if (dt_req)        gnt[PORT_DT] = 1'b1;
      else if (if_req)        gnt[PORT_IF] = 1'b1;
    end
  end

  assign gnt_id = onehot_to_id(gnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported synchronous-read main memory between the
// UART loader, core data port and core fetch port, and sequences boot.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter bit BOOT_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [DATA_W-1:0]     ld_wdata,
  input  logic [DATA_W/8-1:0]   ld_wstrb,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_W-1:0]     ld_rdata,

  input  logic                  dt_req,
  input  logic                  dt_we,
  input  logic [ADDR_W-1:0]     dt_addr,
  input  logic [DATA_W-1:0]     dt_wdata,
  input  logic [DATA_W/8-1:0]   dt_wstrb,
  output logic                  dt_gnt,
  output logic                  dt_rvalid,
  output logic [DATA_W-1:0]     dt_rdata,

  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,

  input  logic                  boot_done,
  output logic                  core_stall,

  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam arb_state_e        RST_ST  = BOOT_EN ? BOOT : RUN;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_d;
  logic             resp_v;
  logic [1:0]       resp_id;

  logic [2:0]       sel_gnt, gnt;
  logic [1:0]       sel_id, gnt_id;
  logic             starved;

  assign starved = (starve_cnt == CNT_MAX);

  arb_prio_sel u_sel (
    .ld_req  (ld_req),
    .dt_req  (dt_req),
    .if_req  (if_req),
    .boot    (state_q == BOOT),
    .starved (starved),
    .gnt     (sel_gnt),
    .gnt_id  (sel_id)
  );

  // Grants are masked while reset is held so every output shows its reset
  // value immediately, independent of the requests.
  assign gnt    = rst ? 3'b000    : sel_gnt;
  assign gnt_id = rst ? PORT_NONE : sel_id;

  assign ld_gnt = gnt[PORT_LD];
  assign dt_gnt = gnt[PORT_DT];
  assign if_gnt = gnt[PORT_IF];

  always_comb begin
    state_d    = state_q;
    core_stall = 1'b0;
    unique case (state_q)
      BOOT: begin
        core_stall = 1'b1;
        if (boot_done) state_d = RUN;
      end
      RUN: ;
      default: state_d = RST_ST;
    endcase
  end

  // Fetch only counts as losing arbitration once the core is running.
  always_comb begin
    starve_cnt_d = '0;
    if (state_q == RUN && if_req && !gnt[PORT_IF])
      starve_cnt_d = starved ? starve_cnt : starve_cnt + CNT_W'(1);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (gnt_id)
      PORT_LD: begin
        mem_en    = 1'b1;
        mem_we    = ld_we ? ld_wstrb : '0;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      PORT_DT: begin
        mem_en    = 1'b1;
        mem_we    = dt_we ? dt_wstrb : '0;
        mem_addr  = dt_addr;
        mem_wdata = dt_wdata;
      end
      PORT_IF: begin
        mem_en    = 1'b1;
        mem_addr  = if_addr;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_ST;
      starve_cnt <= '0;
      resp_v     <= 1'b0;
      resp_id    <= PORT_NONE;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_cnt_d;
      resp_v     <= |gnt;
      resp_id    <= gnt_id;
    end
  end

  // Every grant, read or write, produces exactly one response next cycle.
  assign ld_rvalid = resp_v && (resp_id == PORT_LD);
  assign dt_rvalid = resp_v && (resp_id == PORT_DT);
  assign if_rvalid = resp_v && (resp_id == PORT_IF);

  assign ld_rdata = ld_rvalid ? mem_rdata : '0;
  assign dt_rdata = dt_rvalid ? mem_rdata : '0;
  assign if_rdata = if_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported, synchronous-read main memory between three requesters: the UART program loader, the core data port, and the core instruction-fetch port. It also sequences boot: the core is held in stall while the loader fills memory, then released. It sits in `top` between `core`, the UART loader, and the memory macro.

## Interface
Parameters:
- `ADDR_W`, 14, word-address width (16 Ki words of 32 bit)
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `STARVE_LIMIT`, 4, consecutive lost cycles after which fetch is promoted above data
- `BOOT_EN`, 1, 1 = come out of reset in BOOT, 0 = come out in RUN

Ports (x ∈ {ld, dt, if}; `if` port has no write fields):
- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `x_req` in 1: request valid; held until `x_gnt`
- `x_we` in 1: 1 = write (ld, dt only)
- `x_addr` in ADDR_W: word address
- `x_wdata` in DATA_W: write data (ld, dt only)
- `x_wstrb` in DATA_W/8: byte enables (ld, dt only)
- `x_gnt` out 1: one-cycle accept pulse
- `x_rvalid` out 1: response pulse, cycle after `x_gnt`
- `x_rdata` out DATA_W: read data, valid with `x_rvalid` on reads
- `boot_done` in 1: loader pulse, ends BOOT
- `core_stall` out 1: holds core PC/regfile
- `mem_en`, `mem_we[DATA_W/8]`, `mem_addr[ADDR_W]`, `mem_wdata[DATA_W]` out; `mem_rdata[DATA_W]` in: memory port, read data one cycle after `mem_en`

## Operation
- States: BOOT, RUN. Reset enters BOOT if `BOOT_EN`, else RUN.
- BOOT: only `ld` is eligible; `dt`/`if` are never granted; `core_stall`=1. `boot_done` moves to RUN on the next edge; a grant in that same cycle still completes.
- RUN: `core_stall`=0. Priority is `ld` > `dt` > `if`. Exception: if `starve_cnt`==STARVE_LIMIT, `if` beats `dt` (never `ld`).
- `starve_cnt`: increments (saturating at STARVE_LIMIT) each cycle `if_req`=1 without `if_gnt`. Clears when `if` is granted or `if_req`=0.
- At most one grant per cycle. The grant is combinational from the current `req` signals and state. `mem_*` are driven combinationally from the granted port: `mem_en`=1, `mem_we`=`wstrb` when `we`, otherwise 0.
- Response: a registered `resp_id` (2 bit) plus `resp_v` route `mem_rdata` to the granted port one cycle later. Every grant, read or write, yields exactly one `x_rvalid`. Each `x_rdata` equals `mem_rdata` when its port is addressed, otherwise 0.
- `boot_done` in RUN is ignored. There is no path back to BOOT except reset.

## Timing
- Grant to `rvalid`: 1 cycle. Back-to-back grants every cycle are allowed, including alternating ports; the responses pipeline in order.
- Writes take effect at the memory edge of the grant cycle. A read granted the next cycle to the same address returns the new data.
- Reset values: all `x_gnt`, `x_rvalid`=0; `x_rdata`=0; `mem_en`=0, `mem_we`=0, `mem_addr`/`mem_wdata`=0; `core_stall`=`BOOT_EN`; `starve_cnt`=0; `resp_v`=0.
- Reset asserted mid-transaction drops the pending response: no `rvalid` follows.
- A requester that drops `req` before `gnt` is legal. A requester that holds `req` after `gnt` starts a new transaction.

## Structure
- `mem_arb_pkg`:
  - state enum {BOOT, RUN}
  - port-id constants PORT_LD=0, PORT_DT=1, PORT_IF=2, PORT_NONE=3
- One sub-module is natural: `arb_prio_sel`. It is combinational, takes the three requests, the state and the starve flag, and returns a one-hot grant plus an id. All registers stay in `mem_port_arbiter`.

## Test plan
- Reset with BOOT_EN=1: `dt_req`/`if_req` held high, `ld` writes 0xDEADBEEF to addr 0x10 → only `ld_gnt`, `core_stall`=1. Then `boot_done` → next cycle `core_stall`=0 and `dt` is granted.
- RUN, `ld` write addr 5 = 0x12345678 with wstrb 0xF, then `dt` read addr 5 on the next cycle → `dt_rvalid` 1 cycle after `dt_gnt` with rdata 0x12345678.
- `dt_req` and `if_req` both held continuously → `dt` gets 4 grants, then `if` on the 5th cycle (starve_cnt=4), then the pattern repeats.
- Byte write to addr 7: 0xAABBCCDD with wstrb 0b0101 over prior 0 → a read returns 0x00BB00DD.
- Alternating `dt` read addr 1 / `if` read addr 2 every cycle → responses arrive in grant order, each on the correct port, with no lost or duplicated `rvalid`.
- `rst` asserted in the cycle after a `dt` read grant → no `dt_rvalid`, and all outputs are at their reset values immediately (asynchronously).
